// File: rtl/flicky_video_timing_if.sv
// Video timing bundle: beam coordinates, blanking/sync, IRQ handshake and pixel path.
interface flicky_video_timing_if;
  logic       PCLK_EN;
  logic [8:0] PH;
  logic [8:0] PV;
  logic       HBLK;
  logic       VBLK;
  logic       HSYNC;
  logic       VSYNC;
  logic       FIELD;
  logic       IRQ;
  logic       IRQ_ACK;
  logic [7:0] RGB8;
  logic [2:0] R;
  logic [2:0] G;
  logic [1:0] B;

  modport master (
    output PCLK_EN, PH, PV, HBLK, VBLK, HSYNC, VSYNC, FIELD, IRQ, R, G, B,
    input  IRQ_ACK, RGB8
  );

  modport slave (
    input  PCLK_EN, PH, PV, HBLK, VBLK, HSYNC, VSYNC, FIELD, IRQ, R, G, B,
    output IRQ_ACK, RGB8
  );
endinterface

// File: rtl/flicky_video_timing.sv
// Flicky raster timing generator: pixel-clock divider, beam counters,
// blanking/sync decodes, vblank IRQ and one-pixel delayed blanked RGB output.
module flicky_video_timing #(
  parameter int unsigned H_TOTAL  = 320,
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned HS_START = 280,
  parameter int unsigned HS_END   = 304,
  parameter int unsigned V_TOTAL  = 262,
  parameter int unsigned V_ACTIVE = 224,
  parameter int unsigned VS_START = 234,
  parameter int unsigned VS_END   = 237
) (
  input  logic                  VCLKx8,
  input  logic                  RESET,
  flicky_video_timing_if.master vid
);

  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT9  = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT9  = 9'(V_ACTIVE);
  localparam logic [8:0] HS_S9   = 9'(HS_START);
  localparam logic [8:0] HS_E9   = 9'(HS_END);
  localparam logic [8:0] VS_S9   = 9'(VS_START);
  localparam logic [8:0] VS_E9   = 9'(VS_END);

  logic [2:0] div_q, div_d;
  logic       pclk_en_q, pclk_en_d;
  logic [8:0] ph_q, ph_d;
  logic [8:0] pv_q, pv_d;
  logic       hblk_q, hblk_d;
  logic       vblk_q, vblk_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       field_q, field_d;
  logic       irq_q, irq_d;
  logic [7:0] pix_q, pix_d;
  logic       blank_q, blank_d;
  logic       line_end;
  logic       frame_end;
  logic       irq_set;
  logic       irq_clr;

  // Next-state: divider, beam counters, decodes of the next beam position, IRQ and pixel pipe.
  always_comb begin
    div_d     = div_q + 3'd1;
    pclk_en_d = (div_q == 3'd6);
    ph_d      = ph_q;
    pv_d      = pv_q;
    field_d   = field_q;
    line_end  = pclk_en_q && (ph_q == H_LAST);
    frame_end = line_end && (pv_q == V_LAST);

    if (pclk_en_q) begin
      if (line_end) begin
        ph_d = '0;
        if (frame_end) begin
          pv_d    = '0;
          field_d = ~field_q;
        end else begin
          pv_d = pv_q + 9'd1;
        end
      end else begin
        ph_d = ph_q + 9'd1;
      end
    end

    // Decoding the next values keeps the flags coincident with the PH/PV they describe.
    hblk_d  = (ph_d >= H_ACT9);
    vblk_d  = (pv_d >= V_ACT9);
    hsync_d = (ph_d >= HS_S9) && (ph_d < HS_E9);
    vsync_d = (pv_d >= VS_S9) && (pv_d < VS_E9);

    // Set has priority over both acknowledge and the end-of-frame auto clear.
    irq_set = line_end && (pv_d == V_ACT9);
    irq_clr = (vid.IRQ_ACK && irq_q) || frame_end;
    irq_d   = irq_set || (irq_q && !irq_clr);

    // Blank flag belongs to the position the captured pixel will be shown at.
    pix_d   = pclk_en_q ? vid.RGB8 : pix_q;
    blank_d = pclk_en_q ? (hblk_d || vblk_d) : blank_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      div_q     <= '0;
      pclk_en_q <= 1'b0;
      ph_q      <= '0;
      pv_q      <= '0;
      hblk_q    <= 1'b0;
      vblk_q    <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      field_q   <= 1'b0;
      irq_q     <= 1'b0;
      pix_q     <= '0;
      blank_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      pclk_en_q <= pclk_en_d;
      ph_q      <= ph_d;
      pv_q      <= pv_d;
      hblk_q    <= hblk_d;
      vblk_q    <= vblk_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      field_q   <= field_d;
      irq_q     <= irq_d;
      pix_q     <= pix_d;
      blank_q   <= blank_d;
    end
  end

  assign vid.PCLK_EN = pclk_en_q;
  assign vid.PH      = ph_q;
  assign vid.PV      = pv_q;
  assign vid.HBLK    = hblk_q;
  assign vid.VBLK    = vblk_q;
  assign vid.HSYNC   = hsync_q;
  assign vid.VSYNC   = vsync_q;
  assign vid.FIELD   = field_q;
  assign vid.IRQ     = irq_q;
  assign vid.R       = blank_q ? 3'd0 : pix_q[2:0];
  assign vid.G       = blank_q ? 3'd0 : pix_q[5:3];
  assign vid.B       = blank_q ? 2'd0 : pix_q[7:6];

endmodule

// File: tb/tb_flicky_video_timing.sv
// Randomized scoreboard bench for flicky_video_timing using a reduced raster.
module tb_flicky_video_timing;

  localparam int unsigned HT = 20;
  localparam int unsigned HA = 12;
  localparam int unsigned HSS = 14;
  localparam int unsigned HSE = 17;
  localparam int unsigned VT = 10;
  localparam int unsigned VA = 6;
  localparam int unsigned VSS = 7;
  localparam int unsigned VSE = 8;
  localparam int unsigned FRAME = 8 * HT * VT;
  localparam int unsigned RUN_CYCLES = 9 * FRAME;

  typedef struct {
    int pclk; int ph; int pv; int hblk; int vblk; int hsync; int vsync;
    int field; int irq; int r; int g; int b;
  } exp_t;

  logic VCLKx8 = 1'b0;
  logic RESET;
  flicky_video_timing_if vif();

  flicky_video_timing #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_END(HSE),
    .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE)
  ) dut (
    .VCLKx8(VCLKx8),
    .RESET (RESET),
    .vid   (vif)
  );

  always #5 VCLKx8 = ~VCLKx8;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done = 0;

  // Reference model: everything derived from edges elapsed since the last reset.
  int unsigned m_n = 0;
  bit          m_irq = 0;
  logic [7:0]  m_pix = '0;

  function automatic exp_t model_view();
    exp_t e;
    int unsigned p, line;
    bit blank;
    p      = m_n / 8;
    line   = p / HT;
    e.pclk = (m_n % 8 == 7) ? 1 : 0;
    e.ph   = int'(p % HT);
    e.pv   = int'(line % VT);
    e.field = int'((line / VT) % 2);
    e.hblk  = (e.ph >= int'(HA)) ? 1 : 0;
    e.vblk  = (e.pv >= int'(VA)) ? 1 : 0;
    e.hsync = (e.ph >= int'(HSS) && e.ph < int'(HSE)) ? 1 : 0;
    e.vsync = (e.pv >= int'(VSS) && e.pv < int'(VSE)) ? 1 : 0;
    e.irq   = m_irq ? 1 : 0;
    blank   = (e.hblk == 1) || (e.vblk == 1);
    e.r = blank ? 0 : int'(m_pix[2:0]);
    e.g = blank ? 0 : int'(m_pix[5:3]);
    e.b = blank ? 0 : int'(m_pix[7:6]);
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit ack, input logic [7:0] rgb);
    exp_t e;
    bit pe, set, aclr, ackc;
    if (rst) begin
      m_n = 0; m_irq = 0; m_pix = '0;
    end else begin
      ackc = ack && m_irq;
      m_n++;
      pe = (m_n % 8 == 0);
      if (pe) m_pix = rgb;
      e = model_view();
      set  = pe && e.ph == 0 && e.pv == int'(VA);
      aclr = pe && e.ph == 0 && e.pv == 0;
      if (set) m_irq = 1;
      else if (ackc || aclr) m_irq = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares against the DUT.
  initial begin
    exp_t e;
    while (!(done && exp_q.size() == 0)) begin
      @(negedge VCLKx8);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pclk_en", int'(vif.PCLK_EN), e.pclk);
        check("ph",      int'(vif.PH),      e.ph);
        check("pv",      int'(vif.PV),      e.pv);
        check("hblk",    int'(vif.HBLK),    e.hblk);
        check("vblk",    int'(vif.VBLK),    e.vblk);
        check("hsync",   int'(vif.HSYNC),   e.hsync);
        check("vsync",   int'(vif.VSYNC),   e.vsync);
        check("field",   int'(vif.FIELD),   e.field);
        check("irq",     int'(vif.IRQ),     e.irq);
        check("r",       int'(vif.R),       e.r);
        check("g",       int'(vif.G),       e.g);
        check("b",       int'(vif.B),       e.b);
      end
    end
  end

  // Driver: picks inputs from the model's view of the beam, advances the model, pushes expectations.
  initial begin
    exp_t cur;
    bit   rst_i, ack_i, did_reset;
    logic [7:0] rgb_i;
    int unsigned fidx, div, rst_hold;
    did_reset = 0;
    rst_hold  = 0;
    RESET = 1'b1; vif.IRQ_ACK = 1'b0; vif.RGB8 = '0;
    repeat (5) begin
      @(posedge VCLKx8); #1;
      model_step(1'b1, 1'b0, 8'h00);
      exp_q.push_back(model_view());
    end
    for (int unsigned cyc = 0; cyc < RUN_CYCLES; cyc++) begin
      cur  = model_view();
      fidx = m_n / FRAME;
      div  = m_n % 8;
      rgb_i = 8'($urandom);
      if (cur.ph == 10 && cur.pv == 2) rgb_i = 8'hA5;
      if (cur.ph == int'(HA) - 1) rgb_i = 8'hFF;
      ack_i = 1'b0;
      if (fidx == 1)
        ack_i = (cur.pv == int'(VA) - 1 && cur.ph == int'(HT) - 1 && div == 7) ||
                (cur.pv == int'(VA) && cur.ph == 0 && div == 0);
      else if (fidx == 2)
        ack_i = (cur.pv == int'(VA) + 2 && cur.ph == 3 && div == 2);
      else if (fidx >= 3)
        ack_i = ($urandom_range(0, 24) == 0);
      rst_i = 1'b0;
      if (rst_hold > 0) begin
        rst_i = 1'b1;
        rst_hold--;
      end else if (!did_reset && fidx == 4 && cur.pv == 5 && cur.ph == 7 && div == 3) begin
        rst_i = 1'b1;
        did_reset = 1;
      end else if (did_reset && $urandom_range(0, 2999) == 0) begin
        rst_i = 1'b1;
        rst_hold = $urandom_range(0, 2);
      end
      RESET = rst_i; vif.IRQ_ACK = ack_i; vif.RGB8 = rgb_i;
      @(posedge VCLKx8); #1;
      model_step(rst_i, ack_i, rgb_i);
      exp_q.push_back(model_view());
    end
    done = 1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge VCLKx8);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
